code_sequencer: RTL and testbench
=================================

Name: code_sequencer

Overview:
- Upstream feeder for the 7-segment pattern indicator: generates the 4-bit `code` consumed by the pattern decoder.
- Steps `code` through 0..MAX_CODE at a programmable dwell rate. Direction is selectable, and a synchronous load is provided.
- A debounced pushbutton toggles run/pause.
- Output `code` is a registered value, so the downstream decoder sees glitch-free changes.

Parameters:
- MAX_CODE, 7: highest code value. Equals the downstream 8-pattern table size minus 1. Must be ≤ 15.
- DIV_W, 24: width of dwell-period input `div`.
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a button level change. Must be ≥ 1.

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- btn_raw  in  1  raw, asynchronous pushbutton; a debounced rising edge toggles run/pause
- dir  in  1  0 = count up, 1 = count down; sampled on each step
- load  in  1  synchronous load strobe
- load_code  in  4  value loaded when `load` = 1
- div  in  DIV_W  dwell period in clk cycles; 0 is treated as 1
- code  out  4  current code, registered; drives indicator input
- step  out  1  one-cycle pulse, high in the cycle `code` has just advanced by stepping
- running  out  1  1 = RUN state, 0 = PAUSE state

Behaviour:
- Reset (async, rst = 1):
  - code = 0, step = 0, running = 0 (PAUSE).
  - Dwell counter = 0.
  - Sync flops = 0, debounced level = 0, debounce counter = 0.
- Button path:
  - btn_raw passes through a 2-flop synchronizer.
  - The debounce counter increments on each edge where the synchronizer output differs from the debounced level; it clears on any edge where they match.
  - When a mismatch occurs with counter = DEBOUNCE_CYCLES-1, the level flips and the counter clears.
  - A 0→1 level flip toggles `running` at that same edge. 1→0 flips have no effect.
  - Net latency: `running` toggles DEBOUNCE_CYCLES+2 edges after the first edge sampling btn_raw = 1, provided the input is held stable.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
- State machine: two states, PAUSE and RUN, reflected directly on `running`. Only debounced presses change state; `load` does not.
- Dwell timing:
  - div_eff = max(div, 1).
  - In RUN, the dwell counter increments each cycle.
  - A tick occurs on a cycle where counter ≥ div_eff-1. On a tick, the counter clears to 0 and the code steps.
  - Therefore, with div constant, steps are exactly div_eff cycles apart.
  - Lowering `div` below the current count forces a tick on the next cycle (no wrap through 2^DIV_W).
  - In PAUSE, the counter holds. Resume continues from the held count.
- Step arithmetic:
  - Up: code = (code == MAX_CODE) ? 0 : code+1.
  - Down: code = (code == 0) ? MAX_CODE : code-1.
  - `step` is registered high for exactly the cycle following each step edge.
- Load:
  - Highest priority. code = min(load_code, MAX_CODE), counter cleared to 0, step = 0. `running` is unchanged.
  - Load and tick in the same cycle: load wins, no step.
  - Load held high for multiple cycles: code is reloaded every cycle and no steps occur.
- Simultaneous press and tick: the tick decision uses the state before the toggle, so a step in the RUN→PAUSE transition cycle still occurs.
- Reset mid-operation: all state returns to reset values immediately, regardless of clk.
- code is always in the range 0..MAX_CODE; the upper bits are zero when MAX_CODE < 8.

Test Plan:
- Reset then idle: rst pulse, 100 cycles with no button → code = 0, running = 0, step never high.
- Run up with wrap: DEBOUNCE_CYCLES = 4, div = 3, press held → running = 1 at edge 6. Then code 0→1→…→7→0 with steps 3 cycles apart; step is high one cycle per change.
- Down count and div = 0: dir = 1, div = 0, running → code 0→7→6→5 on consecutive cycles, step continuously high.
- Load priority: running, div = 5, assert load with load_code = 12 on the same cycle a tick is due → code = 7 (clamped), no step. Next step occurs 5 cycles later.
- Debounce glitch and pause: 3-cycle btn_raw pulse (DEBOUNCE_CYCLES = 4) → running unchanged. A valid press while running → running = 0, code frozen. A further press → resumes with the remaining dwell count.
- Async reset mid-run: code = 5, counter mid-period, rst asserted between clk edges → code = 0, running = 0, step = 0 immediately.

Source files
------------

// File: rtl/code_sequencer.sv
// Code sequencer: steps a 4-bit indicator code through 0..MAX_CODE at a programmable
// dwell rate, with direction select, synchronous load and a debounced run/pause button.
module code_sequencer #(
  parameter int unsigned MAX_CODE        = 7,
  parameter int unsigned DIV_W           = 24,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic             dir,
  input  logic             load,
  input  logic [3:0]       load_code,
  input  logic [DIV_W-1:0] div,
  output logic [3:0]       code,
  output logic             step,
  output logic             running
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [3:0]  MAX_C   = 4'(MAX_CODE);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {PAUSE = 1'b0, RUN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic               sync1_q, sync2_q;
  logic               db_level_q, db_level_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         code_q, code_d;
  logic               step_q, step_d;

  logic               press;
  logic               tick;
  logic [DIV_W-1:0]   div_m1;
  logic [3:0]         code_next;
  logic [3:0]         load_clamped;

  // div of 0 behaves as 1, so the tick threshold never underflows
  assign div_m1       = (div == '0) ? '0 : div - DIV_W'(1);
  assign tick         = (state_q == RUN) && (cnt_q >= div_m1);
  assign load_clamped = (load_code > MAX_C) ? MAX_C : load_code;
  assign code_next    = dir ? ((code_q == 4'd0) ? MAX_C : code_q - 4'd1)
                            : ((code_q == MAX_C) ? 4'd0 : code_q + 4'd1);

  // Debounce, run/pause toggle, dwell counter and code stepping
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    press      = 1'b0;
    state_d    = state_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    step_d     = 1'b0;

    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = sync2_q;
        press      = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    if (press) begin
      state_d = (state_q == RUN) ? PAUSE : RUN;
    end

    if (load) begin
      code_d = load_clamped;
      cnt_d  = '0;
    end else if (tick) begin
      code_d = code_next;
      cnt_d  = '0;
      step_d = 1'b1;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= PAUSE;
      cnt_q      <= '0;
      code_q     <= 4'd0;
      step_q     <= 1'b0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      step_q     <= step_d;
    end
  end

  assign code    = code_q;
  assign step    = step_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_code_sequencer.sv
// Directed bench for code_sequencer with DEBOUNCE_CYCLES = 4 and MAX_CODE = 7.
module tb_code_sequencer;

  localparam int unsigned DIV_W = 24;
  localparam int unsigned DB    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             btn_raw = 1'b0;
  logic             dir = 1'b0;
  logic             load = 1'b0;
  logic [3:0]       load_code = 4'd0;
  logic [DIV_W-1:0] div = '0;
  logic [3:0]       code;
  logic             step;
  logic             running;

  int checks   = 0;
  int failures = 0;

  code_sequencer #(
    .MAX_CODE        (7),
    .DIV_W           (DIV_W),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .dir       (dir),
    .load      (load),
    .load_code (load_code),
    .div       (div),
    .code      (code),
    .step      (step),
    .running   (running)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn_raw = 1'b0;
    load    = 1'b0;
    rst     = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Hold the button until the debounced edge lands (DB+2 edges)
  task automatic press();
    btn_raw = 1'b1;
    repeat (DB + 2) cyc();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (code !== 4'd0 || running !== 1'b0 || step !== 1'b0) begin
      failures++;
      $display("FAIL reset_values code=%0d running=%0b step=%0b expected 0/0/0", code, running, step);
    end
    div = DIV_W'(1);
    for (int i = 0; i < 100; i++) begin
      cyc();
      checks++;
      if (code !== 4'd0 || running !== 1'b0 || step !== 1'b0) begin
        failures++;
        $display("FAIL idle cycle=%0d code=%0d running=%0b step=%0b expected 0/0/0", i, code, running, step);
      end
    end
  endtask

  task automatic test_run_up_wrap();
    do_reset();
    div = DIV_W'(3);
    dir = 1'b0;
    btn_raw = 1'b1;
    repeat (DB + 1) cyc();
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL run_latency_early running=%0b expected 0", running);
    end
    cyc();
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL run_latency running=%0b expected 1", running);
    end
    btn_raw = 1'b0;
    for (int i = 1; i <= 26; i++) begin
      logic [3:0] exp_code;
      logic       exp_step;
      exp_code = 4'((i / 3) % 8);
      exp_step = ((i % 3) == 0);
      cyc();
      checks++;
      if (code !== exp_code || step !== exp_step || running !== 1'b1) begin
        failures++;
        $display("FAIL run_up i=%0d code=%0d step=%0b running=%0b expected %0d/%0b/1",
                 i, code, step, running, exp_code, exp_step);
      end
    end
  endtask

  task automatic test_down_div0();
    do_reset();
    div = '0;
    dir = 1'b1;
    press();
    btn_raw = 1'b0;
    checks++;
    if (running !== 1'b1 || code !== 4'd0) begin
      failures++;
      $display("FAIL down_start running=%0b code=%0d expected 1/0", running, code);
    end
    for (int i = 1; i <= 4; i++) begin
      logic [3:0] exp_code;
      exp_code = 4'((8 - i) % 8);
      cyc();
      checks++;
      if (code !== exp_code || step !== 1'b1) begin
        failures++;
        $display("FAIL down_div0 i=%0d code=%0d step=%0b expected %0d/1", i, code, step, exp_code);
      end
    end
  endtask

  task automatic test_load_priority();
    do_reset();
    div = DIV_W'(5);
    dir = 1'b0;
    press();
    btn_raw = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++;
      if (code !== 4'd0 || step !== 1'b0) begin
        failures++;
        $display("FAIL load_pre i=%0d code=%0d step=%0b expected 0/0", i, code, step);
      end
    end
    // Tick is due on this edge; load must win
    load = 1'b1;
    load_code = 4'd12;
    cyc();
    load = 1'b0;
    checks++;
    if (code !== 4'd7 || step !== 1'b0 || running !== 1'b1) begin
      failures++;
      $display("FAIL load_clamp code=%0d step=%0b running=%0b expected 7/0/1", code, step, running);
    end
    for (int i = 6; i <= 9; i++) begin
      cyc();
      checks++;
      if (code !== 4'd7 || step !== 1'b0) begin
        failures++;
        $display("FAIL load_dwell i=%0d code=%0d step=%0b expected 7/0", i, code, step);
      end
    end
    cyc();
    checks++;
    if (code !== 4'd0 || step !== 1'b1) begin
      failures++;
      $display("FAIL load_next_step code=%0d step=%0b expected 0/1", code, step);
    end
    div = DIV_W'(1);
    load = 1'b1;
    load_code = 4'd3;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (code !== 4'd3 || step !== 1'b0) begin
        failures++;
        $display("FAIL load_held i=%0d code=%0d step=%0b expected 3/0", i, code, step);
      end
    end
    load = 1'b0;
    cyc();
    checks++;
    if (code !== 4'd4 || step !== 1'b1) begin
      failures++;
      $display("FAIL load_release code=%0d step=%0b expected 4/1", code, step);
    end
    cyc();
    checks++;
    if (code !== 4'd5 || step !== 1'b1 || running !== 1'b1) begin
      failures++;
      $display("FAIL load_div1 code=%0d step=%0b running=%0b expected 5/1/1", code, step, running);
    end
  endtask

  task automatic test_glitch_pause();
    do_reset();
    div = DIV_W'(4);
    dir = 1'b0;
    btn_raw = 1'b1;
    repeat (3) cyc();
    btn_raw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (running !== 1'b0) begin
        failures++;
        $display("FAIL glitch i=%0d running=%0b expected 0", i, running);
      end
    end
    press();
    btn_raw = 1'b0;
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL glitch_then_press running=%0b expected 1", running);
    end
    for (int i = 1; i <= 9; i++) begin
      logic [3:0] exp_code;
      logic       exp_step;
      exp_code = 4'(i / 4);
      exp_step = ((i % 4) == 0);
      cyc();
      checks++;
      if (code !== exp_code || step !== exp_step) begin
        failures++;
        $display("FAIL run_div4 i=%0d code=%0d step=%0b expected %0d/%0b", i, code, step, exp_code, exp_step);
      end
    end
    // Pause press: toggle lands 6 edges later, held count is 3
    press();
    btn_raw = 1'b0;
    checks++;
    if (running !== 1'b0 || code !== 4'd3) begin
      failures++;
      $display("FAIL pause running=%0b code=%0d expected 0/3", running, code);
    end
    for (int i = 16; i <= 25; i++) begin
      cyc();
      checks++;
      if (code !== 4'd3 || step !== 1'b0 || running !== 1'b0) begin
        failures++;
        $display("FAIL paused i=%0d code=%0d step=%0b running=%0b expected 3/0/0", i, code, step, running);
      end
    end
    press();
    btn_raw = 1'b0;
    checks++;
    if (running !== 1'b1 || code !== 4'd3 || step !== 1'b0) begin
      failures++;
      $display("FAIL resume running=%0b code=%0d step=%0b expected 1/3/0", running, code, step);
    end
    cyc();
    checks++;
    if (code !== 4'd4 || step !== 1'b1) begin
      failures++;
      $display("FAIL resume_held_count code=%0d step=%0b expected 4/1", code, step);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    div = DIV_W'(8);
    dir = 1'b0;
    press();
    btn_raw = 1'b0;
    load = 1'b1;
    load_code = 4'd5;
    cyc();
    load = 1'b0;
    repeat (3) cyc();
    checks++;
    if (code !== 4'd5 || running !== 1'b1) begin
      failures++;
      $display("FAIL async_pre code=%0d running=%0b expected 5/1", code, running);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (code !== 4'd0 || running !== 1'b0 || step !== 1'b0) begin
      failures++;
      $display("FAIL async_reset code=%0d running=%0b step=%0b expected 0/0/0", code, running, step);
    end
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run_up_wrap();
    test_down_div0();
    test_load_priority();
    test_glitch_pause();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
